// File: rtl/i2s_audio_receiver.sv
// i2s_audio_receiver: serial ADC stream to a held stereo pair with valid/ready and overrun/framing flags.
// Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified format (no delay bit, LRCK=1 is left).
module i2s_audio_receiver #(
  parameter int DATA_WIDTH    = 24,
  parameter int SLOT_BITS_MAX = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  SCLK,
  input  logic                  LRCK,
  input  logic                  SDOUT,
  output logic [DATA_WIDTH-1:0] Left,
  output logic [DATA_WIDTH-1:0] Right,
  output logic                  Valid,
  input  logic                  Ready,
  output logic                  Overrun,
  output logic                  FrameErr
);
  localparam int CW = $clog2(SLOT_BITS_MAX);
  localparam int NW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {SYNC, DELAY, SHIFT, PAD} state_t;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  localparam logic   LEFT_LVL   = 1'b1;
  localparam state_t SLOT_START = SHIFT;
`else
  localparam logic   LEFT_LVL   = 1'b0;
  localparam state_t SLOT_START = DELAY;
`endif
  state_t state, state_n, cur;
  logic [2:0] sclk_s;
  logic [1:0] lrck_s, sdout_s;
  logic primed, lr_prev, rise, lr, d, lr_edge, too_long, latch, done, short_slot;
  logic [CW-1:0] cnt;
  logic [NW-1:0] nbits, nxt_bits;
  logic [DATA_WIDTH-1:0] shreg, left_word, word;
  // cur is the state that owns the bit arriving on this SCLK edge; the transition bit itself is the delay bit
  always_comb begin
    rise       = sclk_s[1] & ~sclk_s[2];
    lr         = lrck_s[1];
    d          = sdout_s[1];
    lr_edge    = rise && primed && (lr != lr_prev);
    too_long   = rise && !lr_edge && state != SYNC && cnt == CW'(SLOT_BITS_MAX - 1);
    latch      = lr_edge && state != SYNC;
    done       = latch && lr_prev != LEFT_LVL;
    short_slot = latch && nbits != NW'(DATA_WIDTH);
    word       = shreg << (NW'(DATA_WIDTH) - nbits);
    nxt_bits   = lr_edge ? NW'(1) : nbits + NW'(1);
    cur        = lr_edge ? ((state != SYNC || lr == LEFT_LVL) ? SLOT_START : SYNC) : state;
    state_n    = !rise ? state :
                 too_long ? SYNC :
                 cur == DELAY ? SHIFT :
                 (cur == SHIFT && nxt_bits == NW'(DATA_WIDTH)) ? PAD : cur;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= SYNC;
    else state <= state_n;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sclk_s    <= '0;
      lrck_s    <= '0;
      sdout_s   <= '0;
      primed    <= 1'b0;
      lr_prev   <= 1'b0;
      cnt       <= '0;
      nbits     <= '0;
      shreg     <= '0;
      left_word <= '0;
      Left      <= '0;
      Right     <= '0;
      Valid     <= 1'b0;
      Overrun   <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      sclk_s   <= {sclk_s[1:0], SCLK};
      lrck_s   <= {lrck_s[0], LRCK};
      sdout_s  <= {sdout_s[0], SDOUT};
      FrameErr <= short_slot || too_long;
      Overrun  <= done && Valid && !Ready;
      if (rise) begin
        primed  <= 1'b1;
        lr_prev <= lr;
        cnt     <= lr_edge ? '0 : cnt + CW'(1);
        if (cur == SHIFT) begin
          shreg <= lr_edge ? DATA_WIDTH'(d) : {shreg[DATA_WIDTH-2:0], d};
          nbits <= nxt_bits;
        end else if (lr_edge) begin
          shreg <= '0;
          nbits <= '0;
        end
        if (latch && lr_prev == LEFT_LVL) left_word <= word;
      end
      if (done && (!Valid || Ready)) begin
        Left  <= left_word;
        Right <= word;
        Valid <= 1'b1;
      end else if (Ready) Valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_audio_receiver.sv
// tb_i2s_audio_receiver: directed frames for capture, hold/overrun, handshake, framing errors and reset.
module tb_i2s_audio_receiver;
  logic clk = 1'b0, rst, sclk, lrck, sdout, ready;
  logic [23:0] left, right;
  logic valid, overrun, frame_err;
  int checks = 0, failures = 0;
  int xfer = 0, vh = 0, vlow = 0, ov = 0, fe = 0;
  int vlow0, xf0, fe0;
  logic [23:0] last_l = '0, last_r = '0;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  localparam logic LFT = 1'b1;
  localparam int DLY = 0;
`else
  localparam logic LFT = 1'b0;
  localparam int DLY = 1;
`endif
  localparam logic RGT = ~LFT;
  i2s_audio_receiver #(.DATA_WIDTH(24), .SLOT_BITS_MAX(32)) dut (
    .Clk(clk), .Rst(rst), .SCLK(sclk), .LRCK(lrck), .SDOUT(sdout),
    .Left(left), .Right(right), .Valid(valid), .Ready(ready),
    .Overrun(overrun), .FrameErr(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (valid && ready) begin
      xfer++;
      last_l = left;
      last_r = right;
    end
    if (valid) vh++;
    else vlow++;
    if (overrun) ov++;
    if (frame_err) fe++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  function automatic logic [31:0] pat(input logic [23:0] w);
    return (DLY == 1) ? {1'b0, w, 7'b0} : {w, 8'b0};
  endfunction
  task automatic bit_lo(input logic lv, input logic b);
    sclk = 1'b0;
    lrck = lv;
    sdout = b;
    tick(16);
    sclk = 1'b1;
  endtask
  task automatic send_slot(input logic lv, input logic [23:0] w, input int n, input int first);
    logic [31:0] p;
    p = pat(w);
    for (int i = first; i < n; i++) begin
      bit_lo(lv, i < 32 ? p[31-i] : 1'b0);
      tick(16);
    end
  endtask
  initial begin
    logic [31:0] p6;
    rst = 1'b1; sclk = 1'b0; lrck = RGT; sdout = 1'b0; ready = 1'b1;
    tick(3);
    chk("rst_left", left, 0);
    chk("rst_right", right, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frameerr", frame_err, 0);
    rst = 1'b0;
    send_slot(RGT, 24'h0, 32, 0);
    // two clean frames with Ready high
    send_slot(LFT, 24'hA5A5A5, 32, 0);
    send_slot(RGT, 24'h5A5A5A, 32, 0);
    send_slot(LFT, 24'hA5A5A5, 32, 0);
    send_slot(RGT, 24'h5A5A5A, 32, 0);
    send_slot(LFT, 24'hA5A5A5, 32, 0);
    chk("t1_xfers", xfer, 2);
    chk("t1_left", last_l, 32'hA5A5A5);
    chk("t1_right", last_r, 32'h5A5A5A);
    chk("t1_valid_cycles", vh, 2);
    chk("t1_overrun", ov, 0);
    chk("t1_frameerr", fe, 0);
    // consumer stalled across two completions
    ready = 1'b0;
    send_slot(RGT, 24'h5A5A5A, 32, 0);
    send_slot(LFT, 24'h123456, 32, 0);
    send_slot(RGT, 24'hFEDCBA, 32, 0);
    send_slot(LFT, 24'h0F0F0F, 32, 0);
    chk("t2_valid", valid, 1);
    chk("t2_left", left, 32'hA5A5A5);
    chk("t2_right", right, 32'h5A5A5A);
    chk("t2_overrun", ov, 1);
    chk("t2_xfers", xfer, 2);
    // Ready rises in the completion cycle: SCLK rise at t, sync+detect loads on the 3rd posedge
    vlow0 = vlow;
    send_slot(RGT, 24'hF0F0F0, 32, 0);
    p6 = pat(24'h13579B);
    bit_lo(LFT, p6[31]);
    tick(2);
    ready = 1'b1;
    tick(1);
    chk("t3_valid", valid, 1);
    chk("t3_left", left, 32'h0F0F0F);
    chk("t3_right", right, 32'hF0F0F0);
    chk("t3_valid_low", vlow, vlow0);
    chk("t3_overrun", ov, 1);
    tick(13);
    send_slot(LFT, 24'h13579B, 32, 1);
    send_slot(RGT, 24'h2468AC, 32, 0);
    // short left slot: 16 data bits of ones
    fe0 = fe;
    send_slot(LFT, 24'hFFFF00, 16 + DLY, 0);
    send_slot(RGT, 24'h000001, 32, 0);
    chk("t4_prev_left", last_l, 32'h13579B);
    chk("t4_prev_right", last_r, 32'h2468AC);
    ready = 1'b0;
    send_slot(LFT, 24'h777777, 32, 0);
    chk("t4_frameerr", fe, fe0 + 1);
    chk("t4_left", left, 32'hFFFF00);
    chk("t4_right", right, 32'h000001);
    chk("t4_valid", valid, 1);
    // reset in the middle of a right slot
    send_slot(RGT, 24'h888888, 16, 0);
    rst = 1'b1;
    #1;
    chk("t5_left", left, 0);
    chk("t5_right", right, 0);
    chk("t5_valid", valid, 0);
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    xf0 = xfer;
    send_slot(RGT, 24'h888888, 32, 16);
    send_slot(LFT, 24'hABCDEF, 32, 0);
    chk("t5_no_xfer", xfer, xf0);
    chk("t5_valid_idle", valid, 0);
    send_slot(RGT, 24'h654321, 32, 0);
    send_slot(LFT, 24'hA5A5A5, 32, 0);
    chk("t5_xfer", xfer, xf0 + 1);
    chk("t5_first_left", last_l, 32'hABCDEF);
    chk("t5_first_right", last_r, 32'h654321);
    // over-long right slot drops the pair and resynchronises
    fe0 = fe;
    xf0 = xfer;
    send_slot(RGT, 24'h111111, 40, 0);
    chk("t6_frameerr", fe, fe0 + 1);
    send_slot(LFT, 24'h222222, 32, 0);
    send_slot(RGT, 24'h333333, 32, 0);
    send_slot(LFT, 24'h444444, 32, 0);
    chk("t6_xfer", xfer, xf0 + 1);
    chk("t6_left", last_l, 32'h222222);
    chk("t6_right", last_r, 32'h333333);
    chk("t6_frameerr_once", fe, fe0 + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
